fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Read-side consumer for the 8-bit, 8-deep FIFO: pops one byte at a time whenever the FIFO is non-empty and transmits it as an asynchronous serial frame (start, 8 data bits LSB first, optional parity, stop). It sits directly on the FIFO's read port (`REN`, `output_data`, `empty`) and drives the board-level serial line, closing the path that the FIFO's write side opens.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: permits starting a new frame; sampled only in IDLE.
- `empty` in 1: FIFO empty flag.
- `fifo_data` in 8: FIFO `output_data`.
- `REN` out 1: FIFO read enable, one-cycle pulse per byte.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse in the final cycle of the last stop bit.

## Operation
- States: IDLE, READ, WAIT, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `enable`=1 and `empty`=0, go to READ; otherwise stay.
- READ: `REN`=1 for exactly this cycle; go to WAIT.
- WAIT: FIFO presents popped byte this cycle; at end of cycle capture `fifo_data` into 8-bit shift register, clear bit counter, go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles; go to DATA.
- DATA: `tx`=shift[0]; each `CLKS_PER_BIT` cycles shift right, increment bit index 0..7; after bit 7 go to PARITY if `PARITY`!=0, else STOP.
- PARITY: `tx` = XOR of the 8 captured bits (even), inverted (odd); one bit period.
- STOP: `tx`=1 for `STOP_BITS`*`CLKS_PER_BIT` cycles; `frame_done` in last cycle; go to IDLE.
- `REN` and `busy` decode from state register only (glitch-free, no combinational path from `empty`).
- Parity accumulated at capture, not recomputed from the shifting register.

## Timing
- Reset values: `tx`=1, `REN`=0, `busy`=0, `frame_done`=0; state IDLE; counters zero.
- Latency: `enable`&`!empty` sampled in IDLE at edge N -> `REN` high in cycle N+1 -> capture at end of N+2 -> `tx` falls in cycle N+3.
- Frame length: (1 + 8 + parity + STOP_BITS) * `CLKS_PER_BIT` cycles.
- Back-to-back: FIFO still non-empty and `enable`=1 -> exactly 3 cycles of `tx`=1 (IDLE, READ, WAIT) beyond the stop bits between frames.
- `enable` deasserted mid-frame: current frame completes; no new READ.
- `empty` rising during WAIT or later: no effect; the pop is already committed.
- Never asserts `REN` while `empty`=1 is sampled in IDLE (no underflow).
- Reset mid-frame: next cycle `tx`=1, IDLE; popped byte is discarded, not re-read.
- Baud counter wraps at `CLKS_PER_BIT`-1; width is clog2(`CLKS_PER_BIT`).

## Structure
- Shared package `fifo_tx_pkg`: state enumeration, parity encodings (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`), idle line level constant.
- Sub-module `baud_counter`: counts 0..`CLKS_PER_BIT`-1, synchronous clear on state change, emits `bit_end` pulse; instantiated once.
- Top holds FSM, shift register, bit index, parity register.

## Test plan
- Reset then FIFO with 0x01, `CLKS_PER_BIT`=4, `PARITY`=0, `enable`=1 -> `REN` single pulse, `tx` = 0,1,0,0,0,0,0,0,0,1 each held 4 cycles, `frame_done` once, `empty` ends high.
- Write 8 bytes 0x01,0x03,...,0xFF until `full` -> eight frames in order, each separated by exactly 3 idle cycles, 8 `REN` pulses total, `full` drops after first pop.
- `PARITY`=1, byte 0x07 -> parity bit 1; `PARITY`=2, byte 0x07 -> parity bit 0; `STOP_BITS`=2 -> stop high 8 cycles.
- `enable`=0 with FIFO non-empty -> no `REN`, `tx`=1, `busy`=0; deassert `enable` mid-frame of 0xAA -> frame completes, no second `REN`.
- Assert `reset` during DATA bit 3 of 0xF0 -> next cycle `tx`=1, `busy`=0, `REN`=0; after release the following FIFO byte is sent intact.
- `empty`=1 throughout, `enable`=1 for 100 cycles -> `REN` never asserted, `tx` constant 1.

Source files
------------

// File: rtl/fifo_tx_pkg.sv
// fifo_tx_pkg: shared FSM states, parity encodings and idle line level for the FIFO-fed UART transmitter
package fifo_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  localparam logic IDLE_LVL = 1'b1;
endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// baud_counter: bit-period counter 0..CLKS_PER_BIT-1 (clk, reset, i_clr in; o_bit_end last cycle, o_pre_end one before)
module baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_bit_end,
  output logic o_pre_end
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [W-1:0] r_cnt;
  assign o_bit_end = r_cnt == W'(CLKS_PER_BIT - 1);
  assign o_pre_end = r_cnt == W'(CLKS_PER_BIT - 2);
  always_ff @(posedge clk)
    r_cnt <= (reset || i_clr || o_bit_end) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO bytes (REN/fifo_data/empty) and sends them as serial frames on tx (busy, frame_done status)
module fifo_uart_tx import fifo_tx_pkg::*; #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       empty,
  input  logic [7:0] fifo_data,
  output logic       REN,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  state_t r_state;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic r_par;
  logic r_tx;
  logic r_done;
  logic w_bit_end;
  logic w_pre_end;
  logic w_clr;
  logic w_last_stop;
  assign w_clr = r_state inside {S_IDLE, S_READ, S_WAIT};
  assign w_last_stop = r_idx == 3'(STOP_BITS - 1);
  assign REN = r_state == S_READ;
  assign busy = r_state != S_IDLE;
  assign tx = r_tx;
  assign frame_done = r_done;
  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .o_bit_end (w_bit_end),
    .o_pre_end (w_pre_end)
  );
  // tx is registered, so each transition loads the level of the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx <= '0;
      r_par <= 1'b0;
      r_tx <= IDLE_LVL;
      r_done <= 1'b0;
    end else begin
      r_done <= r_state == S_STOP && w_last_stop && w_pre_end;
      case (r_state)
        S_IDLE: begin
          r_tx <= IDLE_LVL;
          if (enable && !empty) r_state <= S_READ;
        end
        S_READ: r_state <= S_WAIT;
        S_WAIT: begin
          r_shift <= fifo_data;
          r_par <= PARITY == PAR_ODD ? ~^fifo_data : ^fifo_data;
          r_idx <= '0;
          r_tx <= 1'b0;
          r_state <= S_START;
        end
        S_START: if (w_bit_end) begin
          r_tx <= r_shift[0];
          r_state <= S_DATA;
        end
        S_DATA: if (w_bit_end) begin
          r_shift <= r_shift >> 1;
          if (r_idx == 3'd7) begin
            r_idx <= '0;
            r_tx <= PARITY != PAR_NONE ? r_par : IDLE_LVL;
            r_state <= PARITY != PAR_NONE ? S_PARITY : S_STOP;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_tx <= r_shift[1];
          end
        end
        S_PARITY: if (w_bit_end) begin
          r_tx <= IDLE_LVL;
          r_state <= S_STOP;
        end
        S_STOP: if (w_bit_end) begin
          r_idx <= w_last_stop ? '0 : r_idx + 1'b1;
          if (w_last_stop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed self-checking bench with an 8-deep FIFO model and three parameterisations
module tb_fifo_uart_tx;
  logic clk = 0;
  logic reset = 1;
  logic en0 = 0;
  logic en_p = 1;
  logic p_empty = 1;
  logic [7:0] p_data = 8'h07;
  logic wr_en = 0;
  logic [7:0] wr_data = '0;
  logic [7:0] fifo_q = '0;
  logic [7:0] mem [8];
  logic [2:0] wp = '0;
  logic [2:0] rp = '0;
  logic [3:0] cnt = '0;
  logic empty0, full;
  logic ren0, tx0, busy0, done0;
  logic ren_e, tx_e, busy_e, done_e;
  logic ren_o, tx_o, busy_o, done_o;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int ren_cnt = 0, done_cnt = 0, low_cnt = 0, t_ren = 0, t_done0 = 0;
  int ren_e_cnt = 0, t_done_e = 0, t_done_o = 0;
  int tf, t_e, t_o, prev;
  logic [15:0] bits, be, bo;
  assign empty0 = cnt == 0;
  assign full = cnt == 8;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ren0 && cnt != 0) begin
      fifo_q <= mem[rp];
      rp <= rp + 1;
    end
    if (wr_en && cnt != 8) begin
      mem[wp] <= wr_data;
      wp <= wp + 1;
    end
    cnt <= cnt + 4'(wr_en && cnt != 8) - 4'(ren0 && cnt != 0);
  end
  always @(negedge clk) begin
    if (ren0) begin ren_cnt++; t_ren = cyc; end
    if (done0) begin done_cnt++; t_done0 = cyc; end
    if (!tx0) low_cnt++;
    if (ren_e) ren_e_cnt++;
    if (done_e) t_done_e = cyc;
    if (done_o) t_done_o = cyc;
  end
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .enable(en0), .empty(empty0), .fifo_data(fifo_q),
    .REN(ren0), .tx(tx0), .busy(busy0), .frame_done(done0));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) dut_e (
    .clk(clk), .reset(reset), .enable(en_p), .empty(p_empty), .fifo_data(p_data),
    .REN(ren_e), .tx(tx_e), .busy(busy_e), .frame_done(done_e));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut_o (
    .clk(clk), .reset(reset), .enable(en_p), .empty(p_empty), .fifo_data(p_data),
    .REN(ren_o), .tx(tx_o), .busy(busy_o), .frame_done(done_o));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] frame(input logic [7:0] b);
    return {6'b0, 1'b1, b, 1'b0};
  endfunction
  function automatic logic txs(input int d);
    return d == 0 ? tx0 : (d == 1 ? tx_e : tx_o);
  endfunction
  task automatic push(input logic [7:0] b);
    wr_en = 1;
    wr_data = b;
    @(negedge clk);
    wr_en = 0;
  endtask
  // waits for the start-bit edge, then samples n bits one cycle into each 4-cycle bit
  task automatic capture(input int d, input int n, output logic [15:0] v, output int t);
    int w = 0;
    v = '0;
    while (txs(d) !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) check("fall_timeout", w, 0);
    t = cyc;
    for (int i = 0; i < n; i++) begin
      repeat (i == 0 ? 1 : 4) @(negedge clk);
      v[i] = txs(d);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", tx0, 1);
    check("rst_ren", ren0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_tx_e", tx_e, 1);
    reset = 0;
    en0 = 1;
    repeat (100) @(negedge clk);
    check("empty_ren", ren_cnt, 0);
    check("empty_tx_low", low_cnt, 0);
    check("empty_busy", busy0, 0);
    push(8'h01);
    capture(0, 10, bits, tf);
    check("frame_01", bits, frame(8'h01));
    check("latency", tf - t_ren, 2);
    repeat (4) @(negedge clk);
    check("ren_once", ren_cnt, 1);
    check("done_once", done_cnt, 1);
    check("done_pos", t_done0 - tf, 39);
    check("empty_after", empty0, 1);
    check("busy_after", busy0, 0);
    en0 = 0;
    push(8'hAA);
    push(8'h55);
    repeat (20) @(negedge clk);
    check("dis_ren", ren_cnt, 1);
    check("dis_busy", busy0, 0);
    check("dis_tx", tx0, 1);
    check("dis_level", cnt, 2);
    en0 = 1;
    @(negedge clk);
    check("ren_pulse", ren0, 1);
    en0 = 0;
    capture(0, 10, bits, tf);
    check("frame_aa", bits, frame(8'hAA));
    repeat (30) @(negedge clk);
    check("dis_mid_ren", ren_cnt, 2);
    check("dis_mid_busy", busy0, 0);
    check("dis_mid_level", cnt, 1);
    en0 = 1;
    capture(0, 10, bits, tf);
    check("frame_55", bits, frame(8'h55));
    repeat (4) @(negedge clk);
    check("ren_55", ren_cnt, 3);
    en0 = 0;
    push(8'hF0);
    push(8'h3C);
    en0 = 1;
    capture(0, 0, bits, tf);
    repeat (17) @(negedge clk);
    check("f0_bit3", tx0, 0);
    check("f0_busy", busy0, 1);
    reset = 1;
    @(negedge clk);
    check("rst_mid_tx", tx0, 1);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_ren", ren0, 0);
    reset = 0;
    capture(0, 10, bits, tf);
    check("frame_3c", bits, frame(8'h3C));
    repeat (4) @(negedge clk);
    check("ren_rst", ren_cnt, 5);
    check("level_rst", cnt, 0);
    en0 = 0;
    for (int k = 0; k < 8; k++) push(8'((1 << (k + 1)) - 1));
    check("full", full, 1);
    en0 = 1;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      capture(0, 10, bits, tf);
      check($sformatf("b2b_frame%0d", k), bits, frame(8'((1 << (k + 1)) - 1)));
      if (k == 0) check("full_drop", full, 0);
      else check($sformatf("b2b_gap%0d", k), tf - prev, 43);
      prev = tf;
    end
    repeat (4) @(negedge clk);
    check("b2b_ren", ren_cnt, 13);
    check("b2b_done", done_cnt, 12);
    check("b2b_empty", empty0, 1);
    p_empty = 0;
    @(negedge clk);
    check("par_ren", ren_e, 1);
    p_empty = 1;
    fork
      capture(1, 12, be, t_e);
      capture(2, 11, bo, t_o);
    join
    repeat (4) @(negedge clk);
    check("frame_even", be, 16'h0E0E);
    check("frame_odd", bo, 16'h040E);
    check("done_even", t_done_e - t_e, 47);
    check("done_odd", t_done_o - t_o, 43);
    check("par_ren_cnt", ren_e_cnt, 1);
    check("par_busy", busy_e, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
